// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait stalls with a timeout watchdog and saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255  // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifidRS,
  input  logic [REG_W-1:0] ifidRT,
  input  logic             ifidUsesRS,
  input  logic             ifidUsesRT,
  input  logic             idexIsLoadInsn,
  input  logic             idexRfWrEnable,
  input  logic [REG_W-1:0] idexRT,
  input  logic             exBrTaken,
  input  logic             dmemReq,
  input  logic             dmemReady,
  output logic             pcStall,
  output logic             ifidStall,
  output logic             ifidFlush,
  output logic             idexStall,
  output logic             idexFlush,
  output logic             exmemStall,
  output logic             memTimeoutErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushEvents
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e           stateQ, stateD;
  logic [WaitW-1:0] waitCntQ, waitCntD;
  logic             errQ, errD;
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  logic memWait;
  logic rsHit, rtHit;
  logic loadUse;

  assign memWait = dmemReq & ~dmemReady;
  assign rsHit   = ifidUsesRS & (ifidRS == idexRT);
  assign rtHit   = ifidUsesRT & (ifidRT == idexRT);
  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign loadUse = idexIsLoadInsn & idexRfWrEnable & (idexRT != '0) & (rsHit | rtHit);

  // Memory-wait FSM next state and watchdog count.
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    errD     = errQ;
    unique case (stateQ)
      StRun: begin
        if (memWait) begin
          stateD   = StMemWait;
          waitCntD = WaitW'(1);
        end
      end
      StMemWait: begin
        if (!memWait) begin
          stateD   = StRun;
          waitCntD = '0;
        end else if (waitCntQ == WaitMax) begin
          stateD = StError;
          errD   = 1'b1;
        end else begin
          waitCntD = waitCntQ + WaitW'(1);
        end
      end
      StError: begin
        errD = 1'b1;
      end
      default: begin
        stateD   = StRun;
        waitCntD = '0;
      end
    endcase
  end

  // Mealy control outputs; the release cycle of a wait falls through to the run priorities.
  always_comb begin
    pcStall    = 1'b0;
    ifidStall  = 1'b0;
    ifidFlush  = 1'b0;
    idexStall  = 1'b0;
    idexFlush  = 1'b0;
    exmemStall = 1'b0;
    if (!rst) begin
      if ((stateQ == StError) || memWait) begin
        pcStall    = 1'b1;
        ifidStall  = 1'b1;
        idexStall  = 1'b1;
        exmemStall = 1'b1;
      end else if (exBrTaken) begin
        // ID instruction is on the wrong path, so any load-use hazard is moot.
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end else if (loadUse) begin
        pcStall   = 1'b1;
        ifidStall = 1'b1;
        idexFlush = 1'b1;
      end
    end
  end

  // State, watchdog and saturating counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StRun;
      waitCntQ  <= '0;
      errQ      <= 1'b0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      errQ     <= errD;
      if (pcStall && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
      if (ifidFlush && (flushCntQ != '1)) begin
        flushCntQ <= flushCntQ + CNT_W'(1);
      end
    end
  end

  assign memTimeoutErr = errQ;
  assign stallCycles   = stallCntQ;
  assign flushEvents   = flushCntQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;
  localparam int TMO   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Control vector order: {pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall}
  localparam logic [5:0] CtlNone  = 6'b000000;
  localparam logic [5:0] CtlStall = 6'b110101;
  localparam logic [5:0] CtlBr    = 6'b001010;
  localparam logic [5:0] CtlLu    = 6'b110010;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] ifidRS, ifidRT, idexRT;
  logic ifidUsesRS, ifidUsesRT, idexIsLoadInsn, idexRfWrEnable;
  logic exBrTaken, dmemReq, dmemReady;
  logic pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall, memTimeoutErr;
  logic [CNT_W-1:0] stallCycles, flushEvents;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  bit mErr;
  int mRun;    // consecutive memWait cycles so far
  int mStall;
  int mFlush;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W      (REG_W),
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifidRS        (ifidRS),
    .ifidRT        (ifidRT),
    .ifidUsesRS    (ifidUsesRS),
    .ifidUsesRT    (ifidUsesRT),
    .idexIsLoadInsn(idexIsLoadInsn),
    .idexRfWrEnable(idexRfWrEnable),
    .idexRT        (idexRT),
    .exBrTaken     (exBrTaken),
    .dmemReq       (dmemReq),
    .dmemReady     (dmemReady),
    .pcStall       (pcStall),
    .ifidStall     (ifidStall),
    .ifidFlush     (ifidFlush),
    .idexStall     (idexStall),
    .idexFlush     (idexFlush),
    .exmemStall    (exmemStall),
    .memTimeoutErr (memTimeoutErr),
    .stallCycles   (stallCycles),
    .flushEvents   (flushEvents)
  );

  function automatic logic [5:0] dutCtl();
    return {pcStall, ifidStall, ifidFlush, idexStall, idexFlush, exmemStall};
  endfunction

  // Expected controls straight from the priority rules.
  function automatic logic [5:0] modelCtl();
    bit mw, lu;
    if (rst) return CtlNone;
    mw = dmemReq && !dmemReady;
    lu = idexIsLoadInsn && idexRfWrEnable && (idexRT != 0) &&
         ((ifidUsesRS && ifidRS == idexRT) || (ifidUsesRT && ifidRT == idexRT));
    if (mErr || mw) return CtlStall;
    if (exBrTaken) return CtlBr;
    if (lu) return CtlLu;
    return CtlNone;
  endfunction

  // Advance one clock and the model with it.
  task automatic tick();
    logic [5:0] c;
    bit mw;
    c  = modelCtl();
    mw = dmemReq && !dmemReady;
    @(posedge clk);
    if (rst) begin
      mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
    end else begin
      if (c[5] && mStall < CMAX) mStall++;
      if (c[3] && mFlush < CMAX) mFlush++;
      if (mw && mRun >= TMO) mErr = 1;
      mRun = mw ? mRun + 1 : 0;
    end
    #1;
  endtask

  task automatic clearInputs();
    ifidRS = '0; ifidRT = '0; idexRT = '0;
    ifidUsesRS = 0; ifidUsesRT = 0; idexIsLoadInsn = 0; idexRfWrEnable = 0;
    exBrTaken = 0; dmemReq = 0; dmemReady = 0;
  endtask

  task automatic setLoadUse();
    idexIsLoadInsn = 1; idexRfWrEnable = 1; idexRT = 5'd5; ifidRS = 5'd5; ifidUsesRS = 1;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    setLoadUse();
    dmemReq = 1;
    rst = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL reset_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
    tick(); tick();
    nChecks++;
    if (stallCycles !== 0 || flushEvents !== 0 || memTimeoutErr !== 0) begin
      nFails++;
      $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b expected 0 0 0",
               stallCycles, flushEvents, memTimeoutErr);
    end
    rst = 0;
    clearInputs();
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL reset_idle_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
  endtask

  task automatic test_load_use();
    doReset();
    setLoadUse();
    #1;
    nChecks++;
    if (dutCtl() !== CtlLu) begin
      nFails++; $display("FAIL load_use_ctl: got %b expected %b", dutCtl(), CtlLu);
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone || stallCycles !== 1) begin
      nFails++;
      $display("FAIL load_use_after: got ctl=%b stall=%0d expected %b 1", dutCtl(), stallCycles,
               CtlNone);
    end
    // rt operand path
    idexIsLoadInsn = 1; idexRfWrEnable = 1; idexRT = 5'd9; ifidRT = 5'd9; ifidUsesRT = 1;
    ifidRS = 5'd9;
    #1;
    nChecks++;
    if (dutCtl() !== CtlLu) begin
      nFails++; $display("FAIL load_use_rt: got %b expected %b", dutCtl(), CtlLu);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    doReset();
    setLoadUse();
    idexRT = 5'd0; ifidRS = 5'd0;
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL reg0_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
    tick();
    setLoadUse();
    ifidUsesRS = 0;
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL no_use_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
    tick();
    setLoadUse();
    idexRfWrEnable = 0;
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL no_wr_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
    tick();
    nChecks++;
    if (stallCycles !== 0 || flushEvents !== 0) begin
      nFails++;
      $display("FAIL no_hazard_cnt: got stall=%0d flush=%0d expected 0 0", stallCycles,
               flushEvents);
    end
  endtask

  task automatic test_branch_over_load_use();
    doReset();
    setLoadUse();
    exBrTaken = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlBr) begin
      nFails++; $display("FAIL branch_ctl: got %b expected %b", dutCtl(), CtlBr);
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (flushEvents !== 1 || stallCycles !== 0) begin
      nFails++;
      $display("FAIL branch_cnt: got flush=%0d stall=%0d expected 1 0", flushEvents, stallCycles);
    end
  endtask

  task automatic test_mem_wait();
    doReset();
    dmemReq = 1; dmemReady = 0;
    exBrTaken = 1;  // frozen during the wait, acted on at release
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++;
      if (dutCtl() !== CtlStall) begin
        nFails++; $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, dutCtl(), CtlStall);
      end
      tick();
    end
    dmemReady = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlBr) begin
      nFails++; $display("FAIL mem_release_ctl: got %b expected %b", dutCtl(), CtlBr);
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (stallCycles !== 3 || flushEvents !== 1 || dutCtl() !== CtlNone) begin
      nFails++;
      $display("FAIL mem_wait_cnt: got stall=%0d flush=%0d ctl=%b expected 3 1 %b",
               stallCycles, flushEvents, dutCtl(), CtlNone);
    end
    // Back in RUN: a single new wait cycle stalls again, release without error.
    dmemReq = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlStall) begin
      nFails++; $display("FAIL mem_rewait_ctl: got %b expected %b", dutCtl(), CtlStall);
    end
    tick();
    clearInputs();
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL mem_drop_req_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
  endtask

  task automatic test_watchdog();
    // Exactly TMO wait cycles, ready on the next one: no error.
    doReset();
    dmemReq = 1;
    repeat (TMO) tick();
    dmemReady = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone) begin
      nFails++; $display("FAIL wd_edge_ctl: got %b expected %b", dutCtl(), CtlNone);
    end
    tick();
    clearInputs();
    tick();
    nChecks++;
    if (memTimeoutErr !== 0) begin
      nFails++; $display("FAIL wd_edge_err: got %b expected 0", memTimeoutErr);
    end
    // Held wait: error decided in cycle TMO+1, visible from TMO+2.
    doReset();
    dmemReq = 1;
    for (int c = 1; c <= TMO + 1; c++) begin
      #1;
      nChecks++;
      if (dutCtl() !== CtlStall || memTimeoutErr !== 0) begin
        nFails++;
        $display("FAIL wd_wait[%0d]: got ctl=%b err=%b expected %b 0", c, dutCtl(),
                 memTimeoutErr, CtlStall);
      end
      tick();
    end
    dmemReady = 1;
    exBrTaken = 1;
    #1;
    nChecks++;
    if (dutCtl() !== CtlStall || memTimeoutErr !== 1) begin
      nFails++;
      $display("FAIL wd_error: got ctl=%b err=%b expected %b 1", dutCtl(), memTimeoutErr,
               CtlStall);
    end
    tick(); tick();
    nChecks++;
    if (dutCtl() !== CtlStall || memTimeoutErr !== 1) begin
      nFails++;
      $display("FAIL wd_sticky: got ctl=%b err=%b expected %b 1", dutCtl(), memTimeoutErr,
               CtlStall);
    end
    rst = 1;
    tick();
    rst = 0;
    clearInputs();
    #1;
    nChecks++;
    if (dutCtl() !== CtlNone || memTimeoutErr !== 0 || stallCycles !== 0 || flushEvents !== 0)
    begin
      nFails++;
      $display("FAIL wd_cleared: got ctl=%b err=%b stall=%0d flush=%0d expected all 0",
               dutCtl(), memTimeoutErr, stallCycles, flushEvents);
    end
  endtask

  task automatic test_saturation();
    doReset();
    setLoadUse();
    repeat (10) tick();
    clearInputs();
    #1;
    nChecks++;
    if (stallCycles !== 3'd7) begin
      nFails++; $display("FAIL stall_saturate: got %0d expected 7", stallCycles);
    end
    exBrTaken = 1;
    repeat (9) tick();
    nChecks++;
    if (flushEvents !== 3'd7 || stallCycles !== 3'd7) begin
      nFails++;
      $display("FAIL flush_saturate: got flush=%0d stall=%0d expected 7 7", flushEvents,
               stallCycles);
    end
    clearInputs();
  endtask

  task automatic test_random();
    logic [5:0] exp, got;
    doReset();
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      ifidRS         = REG_W'($urandom_range(0, 3));
      ifidRT         = REG_W'($urandom_range(0, 3));
      idexRT         = REG_W'($urandom_range(0, 3));
      ifidUsesRS     = $urandom_range(0, 1) == 1;
      ifidUsesRT     = $urandom_range(0, 1) == 1;
      idexIsLoadInsn = $urandom_range(0, 1) == 1;
      idexRfWrEnable = $urandom_range(0, 3) != 0;
      exBrTaken      = $urandom_range(0, 4) == 0;
      dmemReq        = $urandom_range(0, 9) < 4;
      dmemReady      = $urandom_range(0, 9) < 4;
      #1;
      exp = modelCtl();
      got = dutCtl();
      nChecks++;
      if (got !== exp) begin
        nFails++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, got, exp);
      end
      nChecks++;
      if ((pcStall && ifidFlush) || (idexStall && idexFlush)) begin
        nFails++; $display("FAIL rand_invariant[%0d]: got %b expected no stall+flush", i, got);
      end
      nChecks++;
      if (stallCycles !== CNT_W'(mStall) || flushEvents !== CNT_W'(mFlush) ||
          memTimeoutErr !== mErr) begin
        nFails++;
        $display("FAIL rand_regs[%0d]: got stall=%0d flush=%0d err=%b expected %0d %0d %b", i,
                 stallCycles, flushEvents, memTimeoutErr, mStall, mFlush, mErr);
      end
      tick();
    end
    rst = 0;
    clearInputs();
  endtask

  initial begin
    rst = 1;
    clearInputs();
    mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_over_load_use();
    test_mem_wait();
    test_watchdog();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that generates the stall and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and by the PC.
- Its `idexFlush` output is the bubble-insert (cHazard) input of the ID/EX register.
- Detects three conditions: load-use data hazards between ID and EX, taken branches resolved in EX, and data-memory wait states.
- Keeps a small FSM for memory waits with a timeout watchdog, plus saturating performance counters.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 32, width of each performance counter.
- MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before error; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifidRS  in  REG_W  rs field of the instruction in ID.
- ifidRT  in  REG_W  rt field of the instruction in ID.
- ifidUsesRS  in  1  ID instruction reads rs.
- ifidUsesRT  in  1  ID instruction reads rt.
- idexIsLoadInsn  in  1  EX instruction is a load.
- idexRfWrEnable  in  1  EX instruction writes the register file.
- idexRT  in  REG_W  destination of the EX load (rt).
- exBrTaken  in  1  branch or jump in EX resolved taken this cycle.
- dmemReq  in  1  MEM stage has an outstanding data-memory access.
- dmemReady  in  1  data memory completes the access this cycle.
- pcStall  out  1  hold the PC.
- ifidStall  out  1  hold the IF/ID register.
- ifidFlush  out  1  load a NOP into IF/ID.
- idexStall  out  1  hold the ID/EX register.
- idexFlush  out  1  load a bubble into ID/EX (cHazard).
- exmemStall  out  1  hold the EX/MEM register.
- memTimeoutErr  out  1  sticky watchdog error.
- stallCycles  out  CNT_W  cycles with pcStall=1.
- flushEvents  out  CNT_W  cycles with ifidFlush=1.

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values: state=RUN, waitCnt=0, memTimeoutErr=0, stallCycles=0, flushEvents=0. With reset asserted, all stall and flush outputs are 0 and the counters do not increment. Reset mid-wait abandons the wait; it is not held over.
- Output timing: control outputs are combinational from the registered state and the current inputs (Mealy), so they act in the same cycle. Counters and `memTimeoutErr` are registered.
- `memWait` = dmemReq & ~dmemReady.
- `loadUse` = idexIsLoadInsn & idexRfWrEnable & (idexRT≠0) & ((ifidUsesRS & ifidRS==idexRT) | (ifidUsesRT & ifidRT==idexRT)). Register 0 never causes a hazard.
- Priority in RUN, highest first:
  - memWait: pcStall, ifidStall, idexStall and exmemStall = 1; no flushes. The EX branch is frozen and re-evaluated when the wait ends.
  - exBrTaken: ifidFlush=1 and idexFlush=1; no stalls. This overrides loadUse, because the ID instruction is on the wrong path.
  - loadUse: pcStall=1, ifidStall=1, idexFlush=1. Lasts one cycle only, since the next cycle sees a bubble in EX.
  - Otherwise all controls are 0.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN → MEM_WAIT when memWait; waitCnt←1.
  - MEM_WAIT: all four stalls = 1 while memWait; waitCnt increments each cycle.
  - MEM_WAIT → RUN in the cycle dmemReady=1 (or dmemReq drops). That cycle is evaluated with the RUN priority rules; waitCnt←0.
  - MEM_WAIT → ERROR when memWait and waitCnt==MEM_TIMEOUT.
  - ERROR: all four stalls = 1, no flushes, memTimeoutErr=1. Exit only by rst.
  - Timeout arithmetic: with MEM_TIMEOUT=N, a wait of exactly N cycles completing on cycle N+1 does not error. The first memWait cycle with waitCnt==N enters ERROR.
- Counters:
  - stallCycles increments in every cycle with pcStall=1.
  - flushEvents increments in every cycle with ifidFlush=1.
  - Both saturate at all-ones and do not wrap.
- Simultaneous events:
  - memWait with exBrTaken: stall only; the flush occurs on the release cycle if exBrTaken is still asserted.
  - memWait with loadUse: stall only.
  - exBrTaken with loadUse: flush only; stallCycles is unchanged.
- Invariant: stall and flush of the same register are never both 1.

Test Plan:
1. Load-use: idexIsLoadInsn=1, idexRfWrEnable=1, idexRT=5, ifidRS=5, ifidUsesRS=1 for one cycle → pcStall=ifidStall=idexFlush=1 for exactly that cycle; stallCycles 0→1.
2. Register 0 and no-use: repeat test 1 with idexRT=0, then with ifidUsesRS=0 → all controls 0; counters unchanged.
3. Branch over load-use: exBrTaken=1 in the same cycle as the test 1 hazard → ifidFlush=idexFlush=1, pcStall=0; flushEvents=1, stallCycles=0.
4. Memory wait: dmemReq=1, dmemReady=0 for 3 cycles, then dmemReady=1 → four stalls high for 3 cycles, all 0 on the 4th; stallCycles=3; state returns to RUN.
5. Watchdog: MEM_TIMEOUT=4, dmemReq=1, dmemReady=0 held → ERROR entered on cycle 5, memTimeoutErr=1 from cycle 6, stalls held. Raising dmemReady does not clear it; rst=1 for one cycle clears everything to reset values.
6. Saturation: CNT_W=3, hold loadUse conditions for 10 cycles → stallCycles reaches 7 and stays at 7.
